mosaic: RTL and testbench
=========================

MOSAIC -- requirements
Module: mosaic

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 start  input  1  one-cycle pulse; begins one full-frame readout when sampled in IDLE.
REQ-004 addr_r / addr_g / addr_b  output  14 each  read address for R/G/B frame memories (row = addr[13:7], col = addr[6:0]).
REQ-005 rdata_r / rdata_g / rdata_b  input  8 each  memory read data, valid the cycle after the address is driven.
REQ-006 out_valid  output  1  data_out holds a Bayer pixel.
REQ-007 out_ready  input  1  sink accepts the pixel when out_valid && out_ready at a rising edge.
REQ-008 data_out  output  8  Bayer pixel, raster order.
REQ-009 done  output  1  frame complete; held high until the next start or reset.

Function
REQ-010 The block SHALL read a 128x128 RGB frame and emit 16384 Bayer pixels in raster order, addresses 0..16383.
REQ-011 Channel select per pixel: R when row even and col odd; B when row odd and col even; G otherwise (row parity == col parity).
REQ-012 addr_r, addr_g and addr_b SHALL always carry the same address; only the selected channel's rdata is used.
REQ-013 FSM states: IDLE, FILL, STREAM, DRAIN, DONE.
- IDLE->FILL on start.
- FILL->STREAM after the first read issues.
- STREAM->DRAIN after address 16383 issues.
- DRAIN->DONE when the last pixel is accepted.
- DONE->FILL on start.
REQ-014 Latency: with out_ready=1, the first out_valid SHALL rise on the 3rd rising edge after the edge sampling start; throughput SHALL then be 1 pixel/cycle.
REQ-015 Backpressure: while out_valid && !out_ready, data_out and out_valid SHALL hold. No pixel is dropped or duplicated. Address advance stalls once the output register and the one-entry skid buffer are both full.
REQ-016 The skid buffer SHALL capture the in-flight read returning during a stall; on release it SHALL present the skid entry before new reads.
REQ-017 out_valid SHALL never drop without an acceptance, except on reset.
REQ-018 The address counter SHALL be 14 bits and SHALL NOT wrap past 16383 within a frame.
REQ-019 done SHALL rise the cycle after the 16384th acceptance; out_valid SHALL be low in DONE.
REQ-020 start asserted outside IDLE/DONE SHALL be ignored.
REQ-021 start in DONE SHALL clear done on the next edge and restart from address 0.

Reset
REQ-022 On reset: state=IDLE, address counter=0, addr_r/g/b=0, data_out=0, out_valid=0, done=0, skid buffer empty.
REQ-023 Reset mid-frame SHALL abort the frame with no further out_valid; the next start begins at address 0.

Structure
REQ-024 Package mosaic_pkg SHALL hold IMG_W=128, IMG_H=128, ADDR_W=14, PIX_W=8, the FSM state encoding and the channel-select encoding (CH_R, CH_G, CH_B).
REQ-025 The one-entry skid buffer SHALL be a sub-module, mosaic_skid (valid/ready in, valid/ready out, 8-bit data).
REQ-026 The selected channel SHALL be delayed one cycle alongside the address so that it aligns with the returning rdata.

Verification
REQ-027 Reset: assert reset mid-frame at pixel 500 -> out_valid=0, done=0, addr_r=0 within the same cycle; the next start yields first pixel = G[0].
REQ-028 Frame, out_ready=1, memories R[a]=a[7:0], G[a]=~a[7:0], B[a]=a[7:0]^8'h5A:
- pixel0=8'hFF, pixel1=8'h01, pixel128=8'hDA, pixel129=8'h7E;
- 16384 pixels, done one cycle after the last.
REQ-029 Backpressure: out_ready low for 7 cycles at pixel 300, then random 50% -> data_out held while stalled; the sequence is identical to REQ-028.
REQ-030 Latency: start at edge N with out_ready=1 -> out_valid first high after edge N+3; 16384 consecutive accept cycles.
REQ-031 start pulsed at pixel 1000 mid-frame -> ignored; the frame completes with 16384 pixels, done once.
REQ-032 start in DONE -> done low next cycle; a second identical frame is emitted.

Source files
------------

// File: rtl/mosaic_pkg.sv
// Shared constants, FSM state encoding and Bayer channel selection for the mosaic readout.
package mosaic_pkg;

  localparam int unsigned IMG_W   = 128;
  localparam int unsigned IMG_H   = 128;
  localparam int unsigned ADDR_W  = 14;
  localparam int unsigned PIX_W   = 8;
  localparam int unsigned COL_W   = $clog2(IMG_W);
  localparam int unsigned NUM_PIX = IMG_W * IMG_H;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StStream,
    StDrain,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    CH_R,
    CH_G,
    CH_B
  } chan_e;

  // Row parity is the LSB of the row field, column parity the LSB of the address.
  function automatic chan_e chan_sel(input logic [ADDR_W-1:0] addr);
    logic row_odd;
    logic col_odd;
    row_odd = addr[COL_W];
    col_odd = addr[0];
    if (!row_odd && col_odd) begin
      return CH_R;
    end else if (row_odd && !col_odd) begin
      return CH_B;
    end else begin
      return CH_G;
    end
  endfunction

endpackage

// File: rtl/mosaic_skid.sv
// Output register plus one-entry skid buffer; the skid entry absorbs a read returning during a stall.
module mosaic_skid
  import mosaic_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_data
);

  logic [PIX_W-1:0] out_q;
  logic [PIX_W-1:0] skid_q;
  logic             out_v_q;
  logic             skid_v_q;
  logic             pop;

  assign pop = out_ready || !out_v_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q    <= '0;
      skid_q   <= '0;
      out_v_q  <= 1'b0;
      skid_v_q <= 1'b0;
    end else if (pop) begin
      // The skid entry is older than anything on in_data, so it goes out first.
      if (skid_v_q) begin
        out_q    <= skid_q;
        out_v_q  <= 1'b1;
        skid_v_q <= 1'b0;
      end else begin
        out_v_q <= in_valid;
        if (in_valid) begin
          out_q <= in_data;
        end
      end
    end else if (in_valid && !skid_v_q) begin
      skid_q   <= in_data;
      skid_v_q <= 1'b1;
    end
  end

  assign in_ready  = !skid_v_q;
  assign out_valid = out_v_q;
  assign out_data  = out_q;

endmodule

// File: rtl/mosaic.sv
// Reads a 128x128 RGB frame from three memories and streams it out as a Bayer mosaic in raster order.
module mosaic
  import mosaic_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] addr_r,
  output logic [ADDR_W-1:0] addr_g,
  output logic [ADDR_W-1:0] addr_b,
  input  logic [PIX_W-1:0]  rdata_r,
  input  logic [PIX_W-1:0]  rdata_g,
  input  logic [PIX_W-1:0]  rdata_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PIX_W-1:0]  data_out,
  output logic              done
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  chan_e             ch_q, ch_d;
  logic              rd_vld_q, rd_vld_d;
  logic              sk_in_ready;
  logic              accept;
  logic [2:0]        occ_next;
  logic              adv;
  logic [PIX_W-1:0]  rd_pix;

  assign accept = out_valid && out_ready;

  // Entries held by output register and skid after this edge; a new read may only complete
  // next cycle if at least one entry is guaranteed free for it.
  assign occ_next = {2'b0, out_valid} + {2'b0, !sk_in_ready} + {2'b0, rd_vld_q} - {2'b0, accept};
  assign adv      = occ_next <= 3'd1;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    ch_d     = ch_q;
    rd_vld_d = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StFill;
          addr_d  = '0;
        end
      end
      StFill: begin
        state_d = StStream;
      end
      StStream: begin
        // While stalled the address holds, so the memory keeps re-reading it harmlessly.
        if (adv) begin
          rd_vld_d = 1'b1;
          ch_d     = chan_sel(addr_q);
          if (addr_q == LAST_ADDR) begin
            state_d = StDrain;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (accept && sk_in_ready && !rd_vld_q) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      ch_q     <= CH_G;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      ch_q     <= ch_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  always_comb begin
    case (ch_q)
      CH_R:    rd_pix = rdata_r;
      CH_B:    rd_pix = rdata_b;
      default: rd_pix = rdata_g;
    endcase
  end

  mosaic_skid u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rd_vld_q),
    .in_ready  (sk_in_ready),
    .in_data   (rd_pix),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (data_out)
  );

  assign addr_r = addr_q;
  assign addr_g = addr_q;
  assign addr_b = addr_q;
  assign done   = state_q == StDone;

endmodule

// File: tb/tb_mosaic.sv
// Self-checking bench for mosaic: synchronous frame memories and a raster-order Bayer reference.
module tb_mosaic;

  localparam int NPIX = 16384;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        out_ready;
  logic        out_valid;
  logic        done;
  logic [13:0] addr_r, addr_g, addr_b;
  logic [7:0]  rdata_r, rdata_g, rdata_b;
  logic [7:0]  data_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] got[$];
  int         lat, gaps, holds, done_delay, done_k1, n;
  logic       valid_at_done;

  always #5 clk = ~clk;

  mosaic dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .addr_r    (addr_r),
    .addr_g    (addr_g),
    .addr_b    (addr_b),
    .rdata_r   (rdata_r),
    .rdata_g   (rdata_g),
    .rdata_b   (rdata_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .done      (done)
  );

  // Memories: R[a]=a[7:0], G[a]=~a[7:0], B[a]=a[7:0]^5A, data one cycle after the address.
  always @(posedge clk) begin
    rdata_r <= addr_r[7:0];
    rdata_g <= ~addr_g[7:0];
    rdata_b <= addr_b[7:0] ^ 8'h5A;
  end

  function automatic logic [7:0] exp_pix(input int i);
    int         row;
    int         col;
    logic [7:0] a;
    row = i / 128;
    col = i % 128;
    a   = 8'(i);
    if (row % 2 == 0 && col % 2 == 1) return a;
    else if (row % 2 == 1 && col % 2 == 0) return a ^ 8'h5A;
    else return ~a;
  endfunction

  // Pulses start, collects the frame and records timing facts for the calling test.
  task automatic run_frame(input bit rnd, input int stall_at, input int ignore_at);
    int         k;
    int         last_k;
    int         stall_left;
    bit         stalled_once;
    bit         pulsed;
    bit         prev_stall;
    bit         acc;
    logic [7:0] prev_data;
    got.delete();
    n = 0; lat = -1; gaps = 0; holds = 0; done_delay = -1; done_k1 = -1;
    valid_at_done = 1'b1; last_k = 0; stall_left = 0; stalled_once = 0; pulsed = 0;
    prev_stall = 0; prev_data = '0;
    @(negedge clk);
    out_ready = 1'b1;
    start     = 1'b1;
    for (k = 1; k <= 25000; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 1) done_k1 = int'(done);
      if (lat < 0 && out_valid === 1'b1) lat = k - 1;
      if (prev_stall && !(out_valid === 1'b1 && data_out === prev_data)) holds++;
      if (done === 1'b1) begin
        done_delay    = k - last_k;
        valid_at_done = out_valid;
        break;
      end
      if (n == stall_at && !stalled_once) begin
        stall_left   = 7;
        stalled_once = 1;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else if (rnd && n > stall_at && n < stall_at + 4000) begin
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        out_ready = 1'b1;
      end
      if (n == ignore_at && !pulsed) begin
        start  = 1'b1;
        pulsed = 1;
      end
      acc = (out_valid === 1'b1) && out_ready;
      if (lat >= 0 && n < NPIX && !acc) gaps++;
      if (acc) begin
        got.push_back(data_out);
        n++;
        last_k = k;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_data  = data_out;
    end
    out_ready = 1'b1;
    start     = 1'b0;
  endtask

  task automatic test_reset();
    int cnt;
    bit seen;
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b0 || data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b done=%b data=%h, required 0 0 00",
               out_valid, done, data_out);
    end
    checks++;
    if (addr_r !== 14'd0 || addr_g !== 14'd0 || addr_b !== 14'd0) begin
      errors++;
      $display("FAIL reset_addr: r=%0d g=%0d b=%0d, required 0", addr_r, addr_g, addr_b);
    end
    // Abort a frame at pixel 500.
    cnt = 0;
    @(negedge clk);
    out_ready = 1'b1;
    start     = 1'b1;
    for (int k = 0; k < 2000 && cnt < 500; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid === 1'b1) cnt++;
    end
    checks++;
    if (cnt != 500) begin
      errors++;
      $display("FAIL reset_reach500: got %0d pixels, required 500", cnt);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b0 || addr_r !== 14'd0) begin
      errors++;
      $display("FAIL reset_midframe: valid=%b done=%b addr=%0d, required 0 0 0",
               out_valid, done, addr_r);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_valid: valid=%b, required 0", out_valid);
    end
    start = 1'b1;
    seen  = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      start = 1'b0;
      seen  = out_valid === 1'b1;
    end
    checks++;
    if (!seen || data_out !== exp_pix(0)) begin
      errors++;
      $display("FAIL reset_restart_first: seen=%b data=%h, required 1 %h", seen, data_out,
               exp_pix(0));
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_sequence(input string name);
    int bad;
    bad = 0;
    foreach (got[i]) if (got[i] !== exp_pix(i)) bad++;
    checks++;
    if (bad != 0 || got.size() != NPIX) begin
      errors++;
      $display("FAIL %s_sequence: %0d pixels, %0d wrong, required %0d pixels 0 wrong",
               name, got.size(), bad, NPIX);
    end
  endtask

  task automatic test_frame();
    run_frame(1'b0, -1, -1);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL frame_latency: %0d edges, required 3", lat);
    end
    checks++;
    if (gaps != 0) begin
      errors++;
      $display("FAIL frame_throughput: %0d idle cycles, required 0", gaps);
    end
    checks++;
    if (got.size() < 130 || got[0] !== 8'hFF || got[1] !== 8'h01 || got[128] !== 8'hDA ||
        got[129] !== 8'h7E) begin
      errors++;
      $display("FAIL frame_known_pixels: size=%0d, required FF 01 DA 7E at 0 1 128 129",
               got.size());
    end
    check_sequence("frame");
    checks++;
    if (done_delay != 1 || valid_at_done !== 1'b0) begin
      errors++;
      $display("FAIL frame_done: delay=%0d valid=%b, required 1 0", done_delay, valid_at_done);
    end
  endtask

  task automatic test_backpressure();
    run_frame(1'b1, 300, -1);
    checks++;
    if (holds != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d hold violations, required 0", holds);
    end
    check_sequence("bp");
    checks++;
    if (done_delay != 1 || valid_at_done !== 1'b0) begin
      errors++;
      $display("FAIL bp_done: delay=%0d valid=%b, required 1 0", done_delay, valid_at_done);
    end
  endtask

  task automatic test_restart_ignore();
    int bad;
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL restart_done_held: done=%b valid=%b, required 1 0", done, out_valid);
    end
    run_frame(1'b0, -1, 1000);
    checks++;
    if (done_k1 != 0) begin
      errors++;
      $display("FAIL restart_done_clear: done=%0d after start, required 0", done_k1);
    end
    check_sequence("restart");
    checks++;
    if (done_delay != 1) begin
      errors++;
      $display("FAIL restart_done: delay=%0d, required 1", done_delay);
    end
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (done !== 1'b1 || out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL restart_done_stable: %0d bad cycles, required 0", bad);
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    test_reset_pre();
    test_reset();
    test_frame();
    test_backpressure();
    test_restart_ignore();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Reset state is observed while reset is still asserted, then released.
  task automatic test_reset_pre();
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: valid=%b done=%b, required 0 0", out_valid, done);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

endmodule
